// File: rtl/sar_comp.sv
// Successive-approximation search engine: drives an svreal-format trial code and
// binary-searches, one comparator bit per step, for the largest code not exceeding the unknown.
module sar_comp #(
    parameter int WIDTH    = 16,
    parameter int EXPONENT = -8,
    parameter int SETTLE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    cmp_i,
    output logic signed [WIDTH-1:0] dac_o,
    output logic signed [WIDTH-1:0] result_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    valid_o
);

    localparam int              CW   = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int              KW   = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(SETTLE);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    // EXPONENT only labels the svreal format of the codes; it never changes the search.
    if (WIDTH < 2 || SETTLE < 0 || EXPONENT < -1024 || EXPONENT > 1024) begin : g_paramCheck
        $error("sar_comp: unsupported parameter values");
    end

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_u;
    logic [KW-1:0]      r_k;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_dac;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;

    logic [WIDTH-1:0]   w_kBit;
    logic [WIDTH-1:0]   w_uDecided;
    logic [WIDTH-1:0]   w_uNext;

    // u is offset binary: clearing bit k when the trial overshoots, then arming bit k-1.
    always_comb begin
        w_kBit     = WIDTH'(1) << r_k;
        w_uDecided = cmp_i ? (r_u & ~w_kBit) : r_u;
        w_uNext    = w_uDecided;
        if (r_k != '0) begin
            w_uNext = w_uDecided | (w_kBit >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_u      <= MSB;
            r_k      <= KW'(WIDTH - 1);
            r_cnt    <= '0;
            r_dac    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_u     <= MSB;
                        r_k     <= KW'(WIDTH - 1);
                        r_cnt   <= '0;
                        r_dac   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        r_u   <= w_uNext;
                        r_dac <= w_uNext ^ MSB;
                        if (r_k == '0) begin
                            r_result <= w_uNext ^ MSB;
                            r_done   <= 1'b1;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_k <= r_k - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dac_o    = r_dac;
    assign result_o = r_result;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign valid_o  = r_valid;

endmodule

// File: tb/tb_sar_comp.sv
// Directed bench for sar_comp: a real-valued comparator closes the loop around two
// instances (SETTLE=1 and SETTLE=0) and results are checked against hand-computed codes.
module tb_sar_comp;

   logic clk = 1'b0;
   logic rst;
   logic start0, start1;
   logic cmp0, cmp1;
   logic signed [15:0] dac0, res0, dac1, res1;
   logic busy0, done0, valid0, busy1, done1, valid1;
   real xReal;

   int compareCount = 0;
   int mismatchCount = 0;

   int lat;
   int extraDone;
   logic signed [15:0] trial0, trial1;

   always #5 clk = ~clk;

   // Ideal comparator: trial (scaled by 2^-8) greater than the unknown.
   assign cmp0 = ($itor(dac0) / 256.0) > xReal;
   assign cmp1 = ($itor(dac1) / 256.0) > xReal;

   sar_comp #(.WIDTH(16), .EXPONENT(-8), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst(rst), .start_i(start0), .cmp_i(cmp0),
      .dac_o(dac0), .result_o(res0), .busy_o(busy0), .done_o(done0), .valid_o(valid0)
   );

   sar_comp #(.WIDTH(16), .EXPONENT(-8), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start1), .cmp_i(cmp1),
      .dac_o(dac1), .result_o(res1), .busy_o(busy1), .done_o(done1), .valid_o(valid1)
   );

   // Single point where every comparison is counted and mismatches are reported.
   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      compareCount++;
      if (observed != expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Pulses start on the selected instance, then counts edges after the start edge until done is seen.
   task automatic applyStimulus(input bit sel, input real x, input bit spam,
                                output int latency,
                                output logic signed [15:0] firstTrial,
                                output logic signed [15:0] secondTrial);
      bit seen;
      xReal = x;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      firstTrial = sel ? dac1 : dac0;
      secondTrial = firstTrial;
      latency = 0;
      seen = 1'b0;
      while (!seen && latency < 200) begin
         @(posedge clk); #1;
         latency++;
         if (latency == 2) secondTrial = sel ? dac1 : dac0;
         if (spam && latency < 25) start0 = (latency % 2 == 1);
         seen = sel ? done1 : done0;
      end
      start0 = 1'b0;
      checkOutput("doneSeen", longint'(seen), 1);
   endtask

   initial begin
      rst = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      xReal = 0.0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstDac", dac0, 0);
      checkOutput("rstResult", res0, 0);
      checkOutput("rstBusy", busy0, 0);
      checkOutput("rstDone", done0, 0);
      checkOutput("rstValid", valid0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // x = 1.5 -> 384 after 32 cycles
      applyStimulus(1'b0, 1.5, 1'b0, lat, trial0, trial1);
      checkOutput("lat1p5", lat, 32);
      checkOutput("res1p5", res0, 384);
      checkOutput("valid1p5", valid0, 1);
      checkOutput("busyDone1p5", busy0, 0);
      checkOutput("dacHold1p5", dac0, 384);
      @(posedge clk); #1;
      checkOutput("donePulse1p5", done0, 0);

      // x = -2.3 -> -589, with the first two trials 0 and -16384
      applyStimulus(1'b0, -2.3, 1'b0, lat, trial0, trial1);
      checkOutput("resNeg2p3", res0, -589);
      checkOutput("trial0Neg2p3", trial0, 0);
      checkOutput("trial1Neg2p3", trial1, -16384);

      // Saturation at both ends
      applyStimulus(1'b0, 200.0, 1'b0, lat, trial0, trial1);
      checkOutput("satHigh", res0, 32767);
      applyStimulus(1'b0, -200.0, 1'b0, lat, trial0, trial1);
      checkOutput("satLow", res0, -32768);
      checkOutput("satLowDac", dac0, -32768);

      // Start pulses while busy are ignored
      applyStimulus(1'b0, 0.75, 1'b1, lat, trial0, trial1);
      checkOutput("latSpam", lat, 32);
      checkOutput("resSpam", res0, 192);
      extraDone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done0) extraDone++;
      end
      checkOutput("extraDoneSpam", extraDone, 0);
      checkOutput("busyAfterSpam", busy0, 0);

      // Reset ten cycles into a conversion aborts it
      xReal = 1.5;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checkOutput("busyBeforeRst", busy0, 1);
      rst = 1'b1;
      #1;
      checkOutput("abortBusy", busy0, 0);
      checkOutput("abortDone", done0, 0);
      checkOutput("abortValid", valid0, 0);
      checkOutput("abortResult", res0, 0);
      checkOutput("abortDac", dac0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 0.75, 1'b0, lat, trial0, trial1);
      checkOutput("latAfterRst", lat, 32);
      checkOutput("resAfterRst", res0, 192);
      checkOutput("validAfterRst", valid0, 1);

      // SETTLE = 0 instance: 16-cycle latency, then a start in the done cycle
      applyStimulus(1'b1, -0.5, 1'b0, lat, trial0, trial1);
      checkOutput("latSettle0", lat, 16);
      checkOutput("resSettle0", res1, -128);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      checkOutput("b2bBusy", busy1, 1);
      checkOutput("b2bDac", dac1, 0);
      checkOutput("b2bDone", done1, 0);
      lat = 0;
      while (!done1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("b2bLat", lat, 16);
      checkOutput("b2bRes", res1, -128);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
